// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-back arbiter and RAW scoreboard (optional round-robin: WB_ARB_RR_EN)
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_reg,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_reg,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            wrtEn,
    output logic [AW-1:0]   wrtReg,
    output logic [XLEN-1:0] wrtData,
    input  logic            mark_en,
    input  logic [AW-1:0]   mark_reg,
    input  logic [AW-1:0]   chk_reg1,
    input  logic [AW-1:0]   chk_reg2,
    output logic            busy1,
    output logic            busy2,
    output logic [31:0]     sb_vec
);

    logic            w_grant0;
    logic            w_grant1;
    logic [AW-1:0]   w_sel_reg;
    logic [XLEN-1:0] w_sel_data;

    logic            r_wrt_en;
    logic [AW-1:0]   r_wrt_reg;
    logic [XLEN-1:0] r_wrt_data;
    logic [31:1]     r_sb;

`ifdef WB_ARB_RR_EN
    // r_last_1 = 1 when requester 1 was granted most recently; reset value hands the first tie to requester 0
    logic r_last_1;

    // Grant: a lone requester wins, a tie goes to whoever was not granted last
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant0 = r_last_1;
            w_grant1 = !r_last_1;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    // Remember the most recent grant, x0 write-backs included
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_last_1 <= 1'b1;
        end else if (w_grant0) begin
            r_last_1 <= 1'b0;
        end else if (w_grant1) begin
            r_last_1 <= 1'b1;
        end
    end
`else
    // Fixed priority: the load write-back always wins a tie
    assign w_grant1 = req1_valid;
    assign w_grant0 = req0_valid && !req1_valid;
`endif

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_sel_reg  = w_grant1 ? req1_reg  : req0_reg;
    assign w_sel_data = w_grant1 ? req1_data : req0_data;

    // Register the write port; x0 write-backs are accepted but never enable a write
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wrt_en   <= 1'b0;
            r_wrt_reg  <= '0;
            r_wrt_data <= '0;
        end else if (w_grant0 || w_grant1) begin
            r_wrt_en   <= (w_sel_reg != '0);
            r_wrt_reg  <= w_sel_reg;
            r_wrt_data <= w_sel_data;
        end else begin
            r_wrt_en   <= 1'b0;
        end
    end

    // Pending-write scoreboard: issue marks, commit clears, a same-edge mark wins
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sb <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (mark_en && (mark_reg == AW'(i))) begin
                    r_sb[i] <= 1'b1;
                end else if (r_wrt_en && (r_wrt_reg == AW'(i))) begin
                    r_sb[i] <= 1'b0;
                end
            end
        end
    end

    assign wrtEn   = r_wrt_en;
    assign wrtReg  = r_wrt_reg;
    assign wrtData = r_wrt_data;
    assign sb_vec  = {r_sb, 1'b0};
    assign busy1   = sb_vec[chk_reg1];
    assign busy2   = sb_vec[chk_reg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_reg, req1_reg;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wrtEn;
    logic [4:0]  wrtReg;
    logic [31:0] wrtData;
    logic        mark_en;
    logic [4:0]  mark_reg, chk_reg1, chk_reg2;
    logic        busy1, busy2;
    logic [31:0] sb_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        me;
        logic [4:0]  mr;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        e0;
        logic        e1;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] dt;
    } wr_t;

    vec_t tbl[17];
    wr_t  exp_q[$];

    // bench-side model of write port and scoreboard
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_wen;
    logic [4:0]  m_wreg;
    logic [31:0] m_sb;

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst_(rst_),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .wrtEn(wrtEn), .wrtReg(wrtReg), .wrtData(wrtData),
        .mark_en(mark_en), .mark_reg(mark_reg), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .busy1(busy1), .busy2(busy2), .sb_vec(sb_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %08h want %08h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                                input logic me, input logic [4:0] mr, input logic [4:0] c1,
                                input logic [4:0] c2, input logic e0, input logic e1);
        vec_t v;
        v.v0 = v0; v.r0 = r0; v.d0 = d0;
        v.v1 = v1; v.r1 = r1; v.d1 = d1;
        v.me = me; v.mr = mr; v.c1 = c1; v.c2 = c2;
        v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic model_reset();
        m_reg  = '0;
        m_data = '0;
        m_wen  = 1'b0;
        m_wreg = '0;
        m_sb   = '0;
        exp_q.delete();
    endtask

    // one clock: drive, check grants/busy, push expected write, clock, pop and compare
    task automatic step(input vec_t v, input string tag);
        wr_t         w;
        wr_t         got;
        logic [31:0] nsb;
        req0_valid = v.v0; req0_reg = v.r0; req0_data = v.d0;
        req1_valid = v.v1; req1_reg = v.r1; req1_data = v.d1;
        mark_en = v.me; mark_reg = v.mr; chk_reg1 = v.c1; chk_reg2 = v.c2;
        #1;
        check({tag, "_rdy0"}, {31'b0, req0_ready}, {31'b0, v.e0});
        check({tag, "_rdy1"}, {31'b0, req1_ready}, {31'b0, v.e1});
        check({tag, "_busy1"}, {31'b0, busy1}, {31'b0, m_sb[v.c1]});
        check({tag, "_busy2"}, {31'b0, busy2}, {31'b0, m_sb[v.c2]});
        if (v.e0) begin
            m_reg = v.r0; m_data = v.d0; w.en = (v.r0 != 0);
        end else if (v.e1) begin
            m_reg = v.r1; m_data = v.d1; w.en = (v.r1 != 0);
        end else begin
            w.en = 1'b0;
        end
        w.rg = m_reg;
        w.dt = m_data;
        exp_q.push_back(w);
        nsb = m_sb;
        if (m_wen) nsb[m_wreg] = 1'b0;
        if (v.me && v.mr != 0) nsb[v.mr] = 1'b1;
        nsb[0] = 1'b0;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, "_wrtEn"}, {31'b0, wrtEn}, {31'b0, got.en});
        check({tag, "_wrtReg"}, {27'b0, wrtReg}, {27'b0, got.rg});
        check({tag, "_wrtData"}, wrtData, got.dt);
        m_wen  = got.en;
        m_wreg = got.rg;
        m_sb   = nsb;
        check({tag, "_sb_vec"}, sb_vec, m_sb);
    endtask

    initial begin
        rst_ = 1'b0;
        req0_valid = 0; req0_reg = 0; req0_data = 0;
        req1_valid = 0; req1_reg = 0; req1_data = 0;
        mark_en = 0; mark_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
        model_reset();

        tbl[0]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0,          0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0,            1, 0, 32'h1234,   1, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,          1, 7, 7, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 7, 0, 0, 0);
        tbl[7]  = mk(1, 7, 32'h77,       0, 0, 0,          0, 0, 7, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0,            0, 0, 0,          1, 7, 7, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 7, 0, 0, 0);
        tbl[10] = mk(0, 0, 0,            1, 7, 32'h700,    0, 0, 7, 0, 0, 1);
        tbl[11] = mk(0, 0, 0,            0, 0, 0,          0, 0, 7, 0, 0, 0);
        tbl[12] = mk(0, 0, 0,            0, 0, 0,          0, 0, 7, 0, 0, 0);
        tbl[13] = mk(1, 3, 32'h33,       0, 0, 0,          1, 3, 0, 3, 1, 0);
        tbl[14] = mk(1, 4, 32'h44,       0, 0, 0,          0, 0, 0, 3, 1, 0);
        tbl[15] = mk(0, 0, 0,            1, 9, 32'h99,     0, 0, 0, 3, 0, 1);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,          0, 0, 9, 3, 0, 0);

        // reset state
        #1;
        check("rst_wrtEn", {31'b0, wrtEn}, 32'h0);
        check("rst_wrtReg", {27'b0, wrtReg}, 32'h0);
        check("rst_wrtData", wrtData, 32'h0);
        check("rst_sb_vec", sb_vec, 32'h0);
        check("rst_busy", {30'b0, busy1, busy2}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset while a write is in flight and x1/x2 pending
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "ar_mark1");
        step(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), "ar_mark2");
        step(mk(1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0), "ar_wr5");
        check("ar_pre_sb", sb_vec, 32'h0000_0006);
        check("ar_pre_en", {31'b0, wrtEn}, 32'h1);
        #2;
        rst_ = 1'b0;
        #1;
        check("ar_wrtEn", {31'b0, wrtEn}, 32'h0);
        check("ar_wrtReg", {27'b0, wrtReg}, 32'h0);
        check("ar_sb_vec", sb_vec, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // tie right after reset
`ifdef WB_ARB_RR_EN
        step(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 1, 0), "rr0");
        step(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1), "rr1");
        step(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 1, 0), "rr2");
        step(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1), "rr3");
`else
        step(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1), "fp0");
        step(mk(1, 1, 32'hA1, 1, 2, 32'hB3, 0, 0, 0, 0, 0, 1), "fp1");
        step(mk(1, 1, 32'hA1, 1, 2, 32'hB4, 0, 0, 0, 0, 0, 1), "fp2");
        step(mk(1, 1, 32'hA1, 0, 2, 32'hB4, 0, 0, 0, 0, 1, 0), "fp3");
`endif
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "drain");
        check("q_empty", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the RV32I 32×32 register file. It shares the register file's single write port between two requesters: requester 0 is the ALU/execute write-back, and requester 1 is the load/memory write-back. It drives the registered write-port signals and keeps a per-register pending-write scoreboard, which the decode stage uses to generate RAW-hazard stalls. It sits between the execute/memory stages and the register file.

## Interface
- XLEN, 32, data width of write-back data and register file entries
- AW, 5, register address width (32 architectural registers)

- clk  input  1  clock, rising edge
- rst_  input  1  reset, asynchronous, active-low
- req0_valid  input  1  requester 0 (ALU) has a write-back pending
- req0_reg  input  AW  requester 0 destination register
- req0_data  input  XLEN  requester 0 write data
- req0_ready  output  1  requester 0 write-back accepted this cycle
- req1_valid  input  1  requester 1 (load) has a write-back pending
- req1_reg  input  AW  requester 1 destination register
- req1_data  input  XLEN  requester 1 write data
- req1_ready  output  1  requester 1 write-back accepted this cycle
- wrtEn  output  1  register file write enable, registered
- wrtReg  output  AW  register file write address, registered
- wrtData  output  XLEN  register file write data, registered
- mark_en  input  1  decode issues an instruction that writes mark_reg
- mark_reg  input  AW  destination register being issued
- chk_reg1  input  AW  decode source register 1 under check
- chk_reg2  input  AW  decode source register 2 under check
- busy1  output  1  chk_reg1 has a pending write (combinational)
- busy2  output  1  chk_reg2 has a pending write (combinational)
- sb_vec  output  32  raw scoreboard bits; bit 0 is always 0

## Operation
- **Handshake:** a transfer happens on a rising edge where reqN_valid && reqN_ready. reqN_ready is combinational and depends on both valids and the arbitration state. Requesters hold reg and data stable until they are accepted.
- **Arbitration, at most one grant per cycle:**
  - If only one requester is valid, that requester is granted.
  - If both are valid, the policy is set by the configuration macro.
  - If neither is valid, no requester is granted.
- **Write issue:** on the acceptance edge, wrtReg and wrtData load from the granted requester. wrtEn loads 1 only if the granted reg != 0; otherwise it loads 0.
- **Idle:** with no acceptance, wrtEn loads 0. wrtReg and wrtData hold their previous values.
- **x0 writes:** a write-back to x0 is accepted (ready=1) and dropped. The register file never sees it.
- **Scoreboard mark:** on each edge with mark_en=1 and mark_reg != 0, sb[mark_reg] is set.
- **Scoreboard clear:** on each edge with wrtEn=1, sb[wrtReg] is cleared. This is the same edge on which the register file commits the data.
- **Simultaneous mark and clear of the same register:** mark wins and the bit stays 1. The new instruction's write is still pending.
- **Busy outputs:** busy1 = sb[chk_reg1] and busy2 = sb[chk_reg2]. Both are 0 when the checked register is 0.
- **No forwarding:** decode stalls while busyN=1.
- **Fixed x0 bit:** sb_vec[0] is constant 0.

## Timing
- Reset (rst_=0, asynchronous):
  - wrtEn=0, wrtReg=0, wrtData=0
  - all scoreboard bits 0, so busy1, busy2 and sb_vec are 0
  - round-robin pointer = 1, which gives requester 0 the first tie
- While in reset, req0_ready and req1_ready follow the combinational grant but have no effect.
- Reset asserted mid-operation:
  - an in-flight wrtEn is cancelled immediately
  - all pending scoreboard bits are lost
  - decode must be flushed together with this block
- Latency from acceptance to wrtEn=1 is 1 cycle. The data is readable from the register file from the following cycle.
- Throughput is one write-back per cycle, back-to-back, with no bubble.
- A requester that loses arbitration keeps valid high and is accepted on a later cycle. With round-robin, the worst-case wait is 1 cycle.
- Scoreboard set and clear take effect at the edge. busy reflects the updated bit in the next cycle.

## Configuration
- **WB_ARB_RR_EN defined (round-robin):**
  - when both requesters are valid, grant the one that was not granted most recently
  - the pointer updates on every accepted grant, including x0 writes
- **WB_ARB_RR_EN undefined (fixed priority):**
  - requester 1 (load) always wins a tie
  - the round-robin pointer is not implemented
  - requester 0 may starve; upstream guarantees loads cannot be issued back-to-back indefinitely

## Test plan
- **Reset:** assert rst_=0 mid-cycle while wrtEn=1 and sb_vec=32'h0000_0006 -> wrtEn=0, wrtReg=0 and sb_vec=0 immediately (asynchronous).
- **Single requester:** req0 valid with reg=5, data=32'hDEAD_BEEF -> req0_ready=1. Next cycle: wrtEn=1, wrtReg=5, wrtData=32'hDEAD_BEEF. The following cycle: wrtEn=0.
- **Tie with WB_ARB_RR_EN defined:** both valid for 4 cycles (req0 reg=1, req1 reg=2) -> grants alternate 0,1,0,1 starting with 0. wrtReg sequence is 1,2,1,2 with no bubble.
- **Tie with WB_ARB_RR_EN undefined:** both valid -> req1 is granted every cycle and req0_ready stays 0 until req1_valid drops.
- **x0 write:** req1 valid with reg=0, data=32'h1234 -> req1_ready=1 but wrtEn stays 0. A concurrent mark_reg=0 leaves sb_vec unchanged.
- **Scoreboard:** mark x7, then chk_reg1=7 -> busy1=1. Write-back to x7 with a simultaneous mark_en of x7 -> busy1 stays 1. A second write-back to x7 with no mark -> busy1=0 the cycle after wrtEn.
